// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD-bus CMD-line engine.
// Serialises a 48-bit command frame (start, transmission, index, argument,
// CRC7, end) onto the CMD line, then optionally captures a 48-bit response,
// checks its CRC7 and end bit, and bounds the wait for its start bit.
// Optional build macro SD_CMD_CLK_GATE_EN: when defined, o_sd_clk is parked
// low while idle and the divider restarts on accept. When undefined, the SD
// clock runs freely from reset release.
module sd_cmd_engine #(
    parameter int CLK_DIV      = 4,
    parameter int RESP_TIMEOUT = 64,
    parameter int TRAIL_CLKS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [5:0]  i_cmd_index,
    input  logic [31:0] i_cmd_arg,
    input  logic        i_resp_en,
    output logic        o_done,
    output logic [5:0]  o_resp_index,
    output logic [31:0] o_resp_arg,
    output logic        o_crc_err,
    output logic        o_timeout,
    output logic        o_sd_clk,
    output logic        o_sd_cmd,
    output logic        o_sd_cmd_oe,
    input  logic        i_sd_cmd
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMO_W = $clog2(RESP_TIMEOUT + 1);
    localparam int TRL_W = $clog2(TRAIL_CLKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);
    localparam logic [TRL_W-1:0] TRL_LAST = TRL_W'(TRAIL_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RECV  = 3'd3,
        ST_TRAIL = 3'd4
    } state_t;

    state_t             state_r;
    state_t             next_state_s;

    logic [DIV_W-1:0]   div_cnt_r;
    logic               sd_clk_r;
    logic               div_wrap_s;
    logic               fall_tick_s;
    logic               rise_tick_s;
    logic               accept_s;

    logic               ready_r;
    logic               done_r;
    logic [5:0]         resp_index_r;
    logic [31:0]        resp_arg_r;
    logic               crc_err_r;
    logic               timeout_r;
    logic               sd_cmd_r;
    logic               sd_oe_r;

    logic               resp_en_r;
    logic [39:0]        tx_shift_r;
    logic [6:0]         tx_crc_r;
    logic [5:0]         tx_cnt_r;
    logic [44:0]        rx_shift_r;
    logic [6:0]         rx_crc_r;
    logic [5:0]         rx_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [TRL_W-1:0]   trl_cnt_r;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1, MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign div_wrap_s  = (div_cnt_r == DIV_LAST);
    assign fall_tick_s = div_wrap_s & sd_clk_r;
    assign rise_tick_s = div_wrap_s & ~sd_clk_r;
    assign accept_s    = i_cmd_valid & ready_r & (state_r == ST_IDLE);

    assign o_cmd_ready  = ready_r;
    assign o_done       = done_r;
    assign o_resp_index = resp_index_r;
    assign o_resp_arg   = resp_arg_r;
    assign o_crc_err    = crc_err_r;
    assign o_timeout    = timeout_r;
    assign o_sd_clk     = sd_clk_r;
    assign o_sd_cmd     = sd_cmd_r;
    assign o_sd_cmd_oe  = sd_oe_r;

    // SD clock divider: toggles o_sd_clk each time the counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
            sd_clk_r  <= 1'b0;
        end
`ifdef SD_CMD_CLK_GATE_EN
        else if (state_r == ST_IDLE) begin
            div_cnt_r <= '0;
            sd_clk_r  <= 1'b0;
        end
`endif
        else if (div_wrap_s) begin
            div_cnt_r <= '0;
            sd_clk_r  <= ~sd_clk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_SEND;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (fall_tick_s && (tx_cnt_r == 6'd48)) begin
                    if (resp_en_r) begin
                        next_state_s = ST_WAIT;
                    end else begin
                        next_state_s = ST_TRAIL;
                    end
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (rise_tick_s) begin
                    if (!i_sd_cmd) begin
                        next_state_s = ST_RECV;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        next_state_s = ST_TRAIL;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RECV: begin
                if (rise_tick_s && (rx_cnt_r == 6'd47)) begin
                    next_state_s = ST_TRAIL;
                end else begin
                    next_state_s = ST_RECV;
                end
            end
            ST_TRAIL: begin
                if (rise_tick_s && (trl_cnt_r == TRL_LAST)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_TRAIL;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: frame shifting, response capture, counters and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r      <= 1'b1;
            done_r       <= 1'b0;
            resp_index_r <= 6'd0;
            resp_arg_r   <= 32'd0;
            crc_err_r    <= 1'b0;
            timeout_r    <= 1'b0;
            sd_cmd_r     <= 1'b1;
            sd_oe_r      <= 1'b0;
            resp_en_r    <= 1'b0;
            tx_shift_r   <= 40'd0;
            tx_crc_r     <= 7'd0;
            tx_cnt_r     <= 6'd0;
            rx_shift_r   <= 45'd0;
            rx_crc_r     <= 7'd0;
            rx_cnt_r     <= 6'd0;
            tmo_cnt_r    <= '0;
            trl_cnt_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sd_oe_r  <= 1'b0;
                    sd_cmd_r <= 1'b1;
                    if (accept_s) begin
                        ready_r      <= 1'b0;
                        resp_en_r    <= i_resp_en;
                        tx_shift_r   <= {1'b0, 1'b1, i_cmd_index, i_cmd_arg};
                        tx_crc_r     <= 7'd0;
                        tx_cnt_r     <= 6'd0;
                        rx_crc_r     <= 7'd0;
                        rx_cnt_r     <= 6'd0;
                        tmo_cnt_r    <= '0;
                        trl_cnt_r    <= '0;
                        resp_index_r <= 6'd0;
                        resp_arg_r   <= 32'd0;
                        crc_err_r    <= 1'b0;
                        timeout_r    <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (fall_tick_s) begin
                        if (tx_cnt_r < 6'd40) begin
                            // Header and argument; CRC accumulates as bits leave.
                            sd_oe_r    <= 1'b1;
                            sd_cmd_r   <= tx_shift_r[39];
                            tx_shift_r <= {tx_shift_r[38:0], 1'b0};
                            tx_crc_r   <= crc7_step(tx_crc_r, tx_shift_r[39]);
                            tx_cnt_r   <= tx_cnt_r + 6'd1;
                        end else if (tx_cnt_r < 6'd47) begin
                            sd_oe_r  <= 1'b1;
                            sd_cmd_r <= tx_crc_r[6];
                            tx_crc_r <= {tx_crc_r[5:0], 1'b0};
                            tx_cnt_r <= tx_cnt_r + 6'd1;
                        end else if (tx_cnt_r == 6'd47) begin
                            sd_oe_r  <= 1'b1;
                            sd_cmd_r <= 1'b1;
                            tx_cnt_r <= tx_cnt_r + 6'd1;
                        end else begin
                            // End bit has had its full clock; release the line.
                            sd_oe_r  <= 1'b0;
                            sd_cmd_r <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    sd_oe_r  <= 1'b0;
                    sd_cmd_r <= 1'b1;
                    if (rise_tick_s) begin
                        if (!i_sd_cmd) begin
                            // Start bit is a zero, so the CRC stays at zero.
                            rx_shift_r <= 45'd0;
                            rx_crc_r   <= 7'd0;
                            rx_cnt_r   <= 6'd1;
                        end else if (tmo_cnt_r == TMO_LAST) begin
                            timeout_r <= 1'b1;
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                        end
                    end
                end
                ST_RECV: begin
                    sd_oe_r  <= 1'b0;
                    sd_cmd_r <= 1'b1;
                    if (rise_tick_s) begin
                        rx_shift_r <= {rx_shift_r[43:0], i_sd_cmd};
                        rx_cnt_r   <= rx_cnt_r + 6'd1;
                        if (rx_cnt_r < 6'd40) begin
                            rx_crc_r <= crc7_step(rx_crc_r, i_sd_cmd);
                        end
                        if (rx_cnt_r == 6'd47) begin
                            // Shifter holds bits [45:1]; i_sd_cmd is the end bit.
                            resp_index_r <= rx_shift_r[44:39];
                            resp_arg_r   <= rx_shift_r[38:7];
                            crc_err_r    <= (rx_shift_r[6:0] != rx_crc_r) || !i_sd_cmd;
                        end
                    end
                end
                ST_TRAIL: begin
                    sd_oe_r  <= 1'b0;
                    sd_cmd_r <= 1'b1;
                    if (rise_tick_s) begin
                        if (trl_cnt_r == TRL_LAST) begin
                            done_r  <= 1'b1;
                            ready_r <= 1'b1;
                        end else begin
                            trl_cnt_r <= trl_cnt_r + TRL_W'(1);
                        end
                    end
                end
                default: begin
                    sd_oe_r  <= 1'b0;
                    sd_cmd_r <= 1'b1;
                    ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed testbench for sd_cmd_engine (default build, free-running SD clock).
// A passive monitor collects the serial frame on each SD clock rise while the
// line is driven; a small card model in send_resp drives replies on SD falls.
module tb_sd_cmd_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [5:0]  i_cmd_index = 6'd0;
    logic [31:0] i_cmd_arg = 32'd0;
    logic        i_resp_en = 1'b0;
    logic        o_done;
    logic [5:0]  o_resp_index;
    logic [31:0] o_resp_arg;
    logic        o_crc_err;
    logic        o_timeout;
    logic        o_sd_clk;
    logic        o_sd_cmd;
    logic        o_sd_cmd_oe;
    logic        i_sd_cmd = 1'b1;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          oe_clks = 0;
    logic [47:0] cap = 48'd0;

    sd_cmd_engine #(
        .CLK_DIV      (4),
        .RESP_TIMEOUT (64),
        .TRAIL_CLKS   (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_index  (i_cmd_index),
        .i_cmd_arg    (i_cmd_arg),
        .i_resp_en    (i_resp_en),
        .o_done       (o_done),
        .o_resp_index (o_resp_index),
        .o_resp_arg   (o_resp_arg),
        .o_crc_err    (o_crc_err),
        .o_timeout    (o_timeout),
        .o_sd_clk     (o_sd_clk),
        .o_sd_cmd     (o_sd_cmd),
        .o_sd_cmd_oe  (o_sd_cmd_oe),
        .i_sd_cmd     (i_sd_cmd)
    );

    always #5 clk = ~clk;

    // Count completion pulses.
    always @(negedge clk) begin
        if (o_done === 1'b1) done_cnt++;
    end

    // Collect driven CMD bits as the card would see them.
    always @(posedge o_sd_clk) begin
        if (o_sd_cmd_oe === 1'b1) begin
            cap = {cap[46:0], o_sd_cmd};
            oe_clks++;
        end
    end

    task automatic wait_sd_fall();
        logic prev;
        prev = o_sd_clk;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && o_sd_clk === 1'b0) return;
            prev = o_sd_clk;
        end
        total++; bad++;
        $display("FAIL sd_clk_fall: no falling SD clock within 64 clks");
    endtask

    task automatic wait_oe(input logic val, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (o_sd_cmd_oe === val) return;
        end
        total++; bad++;
        $display("FAIL wait_oe: oe never reached %b within %0d clks", val, bound);
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic resp);
        @(negedge clk);
        i_cmd_index = idx;
        i_cmd_arg   = arg;
        i_resp_en   = resp;
        i_cmd_valid = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        i_cmd_index = ~idx;
        i_cmd_arg   = ~arg;
        i_resp_en   = ~resp;
        total++;
        if (o_cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL accept_ready: o_cmd_ready=%b want 0", o_cmd_ready);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                cyc = i + 1;
                break;
            end
        end
        total++;
        if (cyc < 0) begin
            bad++;
            $display("FAIL done_seen: no o_done within 3000 clks");
        end else begin
            total++;
            if (o_cmd_ready !== 1'b1) begin
                bad++;
                $display("FAIL done_ready: o_cmd_ready=%b want 1", o_cmd_ready);
            end
            @(negedge clk);
            total++;
            if (o_done !== 1'b0) begin
                bad++;
                $display("FAIL done_width: o_done=%b want 0", o_done);
            end
        end
    endtask

    task automatic send_resp(input logic [47:0] frame);
        wait_oe(1'b1, 64);
        wait_oe(1'b0, 1000);
        repeat (5) wait_sd_fall();
        for (int b = 47; b >= 0; b--) begin
            wait_sd_fall();
            i_sd_cmd = frame[b];
        end
        wait_sd_fall();
        i_sd_cmd = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({o_cmd_ready, o_done, o_crc_err, o_timeout} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_ctrl: ready/done/crc/tmo=%b want 1000",
                     {o_cmd_ready, o_done, o_crc_err, o_timeout});
        end
        total++;
        if ({o_resp_index, o_resp_arg} !== 38'd0) begin
            bad++;
            $display("FAIL reset_resp: index=%h arg=%h want 0", o_resp_index, o_resp_arg);
        end
        total++;
        if ({o_sd_clk, o_sd_cmd, o_sd_cmd_oe} !== 3'b010) begin
            bad++;
            $display("FAIL reset_line: clk/cmd/oe=%b want 010", {o_sd_clk, o_sd_cmd, o_sd_cmd_oe});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_cmd0();
        int d0;
        int o0;
        int cyc;
        d0 = done_cnt;
        o0 = oe_clks;
        start_cmd(6'd0, 32'h0000_0000, 1'b0);
        wait_done(cyc);
        total++;
        if (cap !== 48'h40_0000_0000_95) begin
            bad++;
            $display("FAIL cmd0_frame: got %h want 400000000095", cap);
        end
        total++;
        if (oe_clks - o0 !== 48) begin
            bad++;
            $display("FAIL cmd0_oe_clks: got %0d want 48", oe_clks - o0);
        end
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL cmd0_done_cnt: got %0d want 1", done_cnt - d0);
        end
        total++;
        if ({o_crc_err, o_timeout} !== 2'b00) begin
            bad++;
            $display("FAIL cmd0_flags: crc/tmo=%b want 00", {o_crc_err, o_timeout});
        end
        total++;
        if (cyc < 440 || cyc > 456) begin
            bad++;
            $display("FAIL cmd0_latency: got %0d clks want 440..456", cyc);
        end
        total++;
        if ({o_cmd_ready, o_sd_cmd, o_sd_cmd_oe} !== 3'b110) begin
            bad++;
            $display("FAIL cmd0_idle: ready/cmd/oe=%b want 110", {o_cmd_ready, o_sd_cmd, o_sd_cmd_oe});
        end
    endtask

    task automatic test_frames();
        logic [5:0]  idx [2]   = '{6'd17, 6'd8};
        logic [31:0] arg [2]   = '{32'h0000_0000, 32'h0000_01AA};
        logic [47:0] frame [2] = '{48'h51_0000_0000_55, 48'h48_0000_01AA_87};
        int cyc;
        for (int k = 0; k < 2; k++) begin
            start_cmd(idx[k], arg[k], 1'b0);
            wait_done(cyc);
            total++;
            if (cap !== frame[k]) begin
                bad++;
                $display("FAIL frame_%0d: got %h want %h", k, cap, frame[k]);
            end
        end
    endtask

    task automatic test_resp();
        logic [47:0] rsp [3]   = '{48'h08_0000_01AA_13, 48'h08_0000_01AA_17, 48'h08_0000_01AA_12};
        logic        c_exp [3] = '{1'b0, 1'b1, 1'b1};
        int cyc;
        for (int k = 0; k < 3; k++) begin
            start_cmd(6'd8, 32'h0000_01AA, 1'b1);
            send_resp(rsp[k]);
            wait_done(cyc);
            total++;
            if (o_resp_index !== 6'd8 || o_resp_arg !== 32'h0000_01AA) begin
                bad++;
                $display("FAIL resp_fields_%0d: index=%h arg=%h want 08 000001aa", k, o_resp_index, o_resp_arg);
            end
            total++;
            if (o_crc_err !== c_exp[k] || o_timeout !== 1'b0) begin
                bad++;
                $display("FAIL resp_flags_%0d: crc=%b tmo=%b want crc=%b tmo=0", k, o_crc_err, o_timeout, c_exp[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int d0;
        int cyc;
        d0 = done_cnt;
        i_sd_cmd = 1'b1;
        start_cmd(6'd8, 32'h0000_01AA, 1'b1);
        wait_done(cyc);
        repeat (100) @(negedge clk);
        total++;
        if (o_timeout !== 1'b1 || o_crc_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_flags: tmo=%b crc=%b want tmo=1 crc=0", o_timeout, o_crc_err);
        end
        total++;
        if (o_resp_index !== 6'd0 || o_resp_arg !== 32'd0) begin
            bad++;
            $display("FAIL tmo_resp_clear: index=%h arg=%h want 0", o_resp_index, o_resp_arg);
        end
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL tmo_done_cnt: got %0d want 1", done_cnt - d0);
        end
        total++;
        if (cyc < 940 || cyc > 980) begin
            bad++;
            $display("FAIL tmo_latency: got %0d clks want 940..980", cyc);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        int cyc;
        d0 = done_cnt;
        @(negedge clk);
        i_cmd_index = 6'd17;
        i_cmd_arg   = 32'h0000_0000;
        i_resp_en   = 1'b0;
        i_cmd_valid = 1'b1;
        @(negedge clk);
        total++;
        if (o_cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: ready=%b want 0", o_cmd_ready);
        end
        i_cmd_index = 6'd0;
        wait_done(cyc);
        total++;
        if (cap !== 48'h51_0000_0000_55 || o_timeout !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: frame=%h tmo=%b want 510000000055 tmo=0", cap, o_timeout);
        end
        total++;
        if (o_cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_reaccept: ready=%b want 0", o_cmd_ready);
        end
        i_cmd_valid = 1'b0;
        wait_done(cyc);
        total++;
        if (cap !== 48'h40_0000_0000_95 || done_cnt - d0 !== 2) begin
            bad++;
            $display("FAIL b2b_second: frame=%h dones=%0d want 400000000095 dones=2", cap, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        start_cmd(6'd8, 32'h0000_01AA, 1'b0);
        wait_oe(1'b1, 64);
        repeat (20) wait_sd_fall();
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_sd_cmd_oe, o_sd_cmd, o_sd_clk, o_cmd_ready} !== 4'b0101) begin
            bad++;
            $display("FAIL rst_mid_line: oe/cmd/clk/ready=%b want 0101",
                     {o_sd_cmd_oe, o_sd_cmd, o_sd_clk, o_cmd_ready});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (700) @(negedge clk);
        total++;
        if (done_cnt !== d0 || o_sd_cmd_oe !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_nodone: dones=%0d oe=%b want %0d oe=0", done_cnt, o_sd_cmd_oe, d0);
        end
        test_cmd0();
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_frames();
        test_resp();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
